// File: rtl/bcd_pkg.sv
// ---------------------------------------------------------------------------
// bcd_pkg
// Shared constants and types for the packed-BCD adder datapath.
//   BCD_DIGIT_W : width of one BCD digit
//   BCD_MAX     : largest legal decimal digit value
//   BCD_CORR    : correction added to a binary digit sum that exceeds BCD_MAX
//   bcd_digit_t : one 4-bit BCD digit
// ---------------------------------------------------------------------------
package bcd_pkg;

   localparam int BCD_DIGIT_W = 4;
   localparam int BCD_MAX     = 9;
   localparam int BCD_CORR    = 6;

   typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

endpackage : bcd_pkg

// File: rtl/bcd_adder_if.sv
// ---------------------------------------------------------------------------
// bcd_adder_if
// Operand/result bundle of the registered BCD adder.
//   in_valid  : operands a/b/cin are valid this cycle
//   a, b      : packed BCD operands, digit 0 in bits [3:0]
//   cin       : decimal carry-in to digit 0
//   out_valid : sum/cout/err hold a new result this cycle
//   sum       : packed BCD sum
//   cout      : decimal carry-out of the most significant digit
//   err       : a sampled operand digit was greater than 9
//
// Handshake: valid-only, no ready. An edge with in_valid=1 always accepts the
// operands; out_valid is then high for exactly the following cycle. The
// consumer must take every out_valid pulse, there is no way to stall.
//
// Modports: master drives operands (producer/testbench), slave is the adder.
// ---------------------------------------------------------------------------
interface bcd_adder_if
   import bcd_pkg::*;
#(
   parameter int DIGITS = 1
) ();

   logic                          in_valid;
   logic [BCD_DIGIT_W*DIGITS-1:0] a;
   logic [BCD_DIGIT_W*DIGITS-1:0] b;
   logic                          cin;
   logic                          out_valid;
   logic [BCD_DIGIT_W*DIGITS-1:0] sum;
   logic                          cout;
   logic                          err;

   modport master (
      output in_valid, a, b, cin,
      input  out_valid, sum, cout, err
   );

   modport slave (
      input  in_valid, a, b, cin,
      output out_valid, sum, cout, err
   );

endinterface : bcd_adder_if

// File: rtl/bcd_digit_add.sv
// ---------------------------------------------------------------------------
// bcd_digit_add
// Purely combinational single-digit BCD adder with +6 correction.
//   a, b : input digits (values 10..15 are tolerated but flagged)
//   cin  : carry from the next lower digit
//   sum  : corrected digit sum
//   cout : carry to the next higher digit
//   bad  : a or b is not a legal BCD digit
// ---------------------------------------------------------------------------
module bcd_digit_add
   import bcd_pkg::*;
(
   input  bcd_digit_t a,
   input  bcd_digit_t b,
   input  logic       cin,
   output bcd_digit_t sum,
   output logic       cout,
   output logic       bad
);

   // Raw binary digit sum; 5 bits covers 15+15+1.
   logic [BCD_DIGIT_W:0] t;

   always_comb begin
      t    = {1'b0, a} + {1'b0, b} + {{BCD_DIGIT_W{1'b0}}, cin};
      sum  = t[BCD_DIGIT_W-1:0];
      cout = 1'b0;
      if (t > (BCD_DIGIT_W+1)'(BCD_MAX)) begin
         // (t + 6) mod 16 only depends on the low nibble of t.
         sum  = t[BCD_DIGIT_W-1:0] + BCD_DIGIT_W'(BCD_CORR);
         cout = 1'b1;
      end
   end

   assign bad = (a > BCD_DIGIT_W'(BCD_MAX)) || (b > BCD_DIGIT_W'(BCD_MAX));

endmodule : bcd_digit_add

// File: rtl/bcd_adder.sv
// ---------------------------------------------------------------------------
// bcd_adder
// Registered multi-digit packed-BCD adder, one addition per cycle, one cycle
// of latency.
//   DIGITS : number of BCD digits per operand (1..8); must match bus.DIGITS
//   clk    : rising-edge clock
//   rst    : asynchronous active-high reset, clears all outputs at once
//   bus    : bcd_adder_if slave (operands in, registered result out)
// ---------------------------------------------------------------------------
module bcd_adder
   import bcd_pkg::*;
#(
   parameter int DIGITS = 1
) (
   input  logic        clk,
   input  logic        rst,
   bcd_adder_if.slave  bus
);

   localparam int W = BCD_DIGIT_W * DIGITS;

   logic [DIGITS:0]   carry;
   logic [DIGITS-1:0] bad;
   logic [W-1:0]      sum_d;
   logic              cout_d;
   logic              err_d;

   logic [W-1:0]      sum_q;
   logic              cout_q;
   logic              err_q;
   logic              out_valid_q;

   assign carry[0] = bus.cin;

   // Carry ripples through all digits within the cycle.
   for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      bcd_digit_add u_digit (
         .a    (bus.a[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
         .b    (bus.b[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
         .cin  (carry[i]),
         .sum  (sum_d[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
         .cout (carry[i+1]),
         .bad  (bad[i])
      );
   end

   assign cout_d = carry[DIGITS];
   assign err_d  = |bad;

   // Result registers only load on accepted operands so they hold between
   // transactions; out_valid follows in_valid with one cycle of delay.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_q       <= '0;
         cout_q      <= 1'b0;
         err_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         out_valid_q <= bus.in_valid;
         if (bus.in_valid) begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
            err_q  <= err_d;
         end
      end
   end

   assign bus.sum       = sum_q;
   assign bus.cout      = cout_q;
   assign bus.err       = err_q;
   assign bus.out_valid = out_valid_q;

endmodule : bcd_adder

// File: tb/tb_bcd_adder.sv
// ---------------------------------------------------------------------------
// tb_bcd_adder
// Self-checking bench for bcd_adder with a 1-digit and a 4-digit instance.
// ---------------------------------------------------------------------------
module tb_bcd_adder;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   bcd_adder_if #(.DIGITS(1)) bus1 ();
   bcd_adder_if #(.DIGITS(4)) bus4 ();

   bcd_adder #(.DIGITS(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
   bcd_adder #(.DIGITS(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

   // ---------------- scoreboard state ----------------
   // Entry packing: {err, cout, sum[31:0]}
   logic [33:0] exp_q[$];
   logic [33:0] held[2];
   bit          pend;
   int          checks = 0;
   int          errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // Legal operands: ordinary decimal arithmetic on the whole numbers.
   // Illegal digits: apply the digit correction rule to each position.
   function automatic logic [33:0] model(input int d, input logic [31:0] a,
                                         input logic [31:0] b, input bit cin);
      longint va = 0, vb = 0, pw = 1, tot;
      int     c, ai, bi, t;
      bit     e = 0;
      logic [31:0] s = '0;
      for (int i = d - 1; i >= 0; i--) begin
         ai = int'((a >> (4*i)) & 32'hF);
         bi = int'((b >> (4*i)) & 32'hF);
         if (ai > 9 || bi > 9) e = 1;
         va = va * 10 + ai;
         vb = vb * 10 + bi;
         pw = pw * 10;
      end
      if (!e) begin
         tot = va + vb + cin;
         c   = (tot >= pw) ? 1 : 0;
         tot = tot % pw;
         for (int i = 0; i < d; i++) begin
            s[4*i +: 4] = 4'(tot % 10);
            tot = tot / 10;
         end
      end else begin
         c = cin;
         for (int i = 0; i < d; i++) begin
            t = int'((a >> (4*i)) & 32'hF) + int'((b >> (4*i)) & 32'hF) + c;
            if (t > 9) begin
               s[4*i +: 4] = 4'((t + 6) % 16);
               c = 1;
            end else begin
               s[4*i +: 4] = 4'(t);
               c = 0;
            end
         end
      end
      return {e, c[0], s};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic drive(input int d, input bit v, input logic [31:0] a,
                        input logic [31:0] b, input bit cin);
      @(negedge clk);
      bus1.in_valid = 1'b0;
      bus4.in_valid = 1'b0;
      if (d == 1) begin
         bus1.in_valid = v;
         bus1.a        = a[3:0];
         bus1.b        = b[3:0];
         bus1.cin      = cin;
      end else begin
         bus4.in_valid = v;
         bus4.a        = a[15:0];
         bus4.b        = b[15:0];
         bus4.cin      = cin;
      end
      pend = v;
   endtask

   task automatic sample(input int d, input string tag);
      logic [33:0] e;
      logic [31:0] o_sum;
      logic        o_cout, o_err, o_valid;
      int          k;
      @(posedge clk);
      #1;
      k = (d == 1) ? 0 : 1;
      if (d == 1) begin
         o_valid = bus1.out_valid; o_sum = 32'(bus1.sum);
         o_cout  = bus1.cout;      o_err = bus1.err;
      end else begin
         o_valid = bus4.out_valid; o_sum = 32'(bus4.sum);
         o_cout  = bus4.cout;      o_err = bus4.err;
      end
      check({tag, "_valid"}, 32'(o_valid), 32'(pend));
      e = held[k];
      if (pend && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         held[k] = e;
      end
      check({tag, "_sum"},  o_sum,       e[31:0]);
      check({tag, "_cout"}, 32'(o_cout), 32'(e[32]));
      check({tag, "_err"},  32'(o_err),  32'(e[33]));
   endtask

   // Directed add with hand-computed expectation.
   task automatic add(input int d, input logic [31:0] a, input logic [31:0] b,
                      input bit cin, input logic [31:0] es, input bit ec,
                      input bit ee, input string tag);
      exp_q.push_back({ee, ec, es});
      drive(d, 1'b1, a, b, cin);
      sample(d, tag);
   endtask

   task automatic idle(input int d, input string tag);
      drive(d, 1'b0, '0, '0, 1'b0);
      sample(d, tag);
   endtask

   function automatic logic [31:0] rnd_operand(input int d);
      logic [31:0] v = '0;
      for (int i = 0; i < d; i++)
         v[4*i +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                   : 4'($urandom_range(0, 9));
      return v;
   endfunction

   // ---------------- directed + random sequence ----------------
   initial begin
      logic [31:0] ra, rb;
      bit          rc, rv;
      int          rd;

      bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0;
      bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0;
      held[0] = '0;
      held[1] = '0;
      pend    = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      check("rst1_valid", 32'(bus1.out_valid), 32'd0);
      check("rst1_sum",   32'(bus1.sum),       32'd0);
      check("rst1_cout",  32'(bus1.cout),      32'd0);
      check("rst1_err",   32'(bus1.err),       32'd0);
      check("rst4_valid", 32'(bus4.out_valid), 32'd0);
      check("rst4_sum",   32'(bus4.sum),       32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Single digit, no correction.
      add(1, 32'h3, 32'h4, 1'b0, 32'h7, 1'b0, 1'b0, "d1_3p4");
      add(1, 32'h5, 32'h4, 1'b0, 32'h9, 1'b0, 1'b0, "d1_5p4");
      add(1, 32'h2, 32'h3, 1'b1, 32'h6, 1'b0, 1'b0, "d1_2p3c");
      add(1, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, "d1_zero");
      // Single digit, correction.
      add(1, 32'h5, 32'h5, 1'b0, 32'h0, 1'b1, 1'b0, "d1_5p5");
      add(1, 32'h9, 32'h9, 1'b0, 32'h8, 1'b1, 1'b0, "d1_9p9");
      add(1, 32'h8, 32'h1, 1'b1, 32'h0, 1'b1, 1'b0, "d1_8p1c");
      add(1, 32'h9, 32'h9, 1'b1, 32'h9, 1'b1, 1'b0, "d1_9p9c");
      // Illegal digit, then a legal add clears err.
      add(1, 32'hC, 32'h1, 1'b0, 32'h3, 1'b1, 1'b1, "d1_bad");
      add(1, 32'h1, 32'h1, 1'b0, 32'h2, 1'b0, 1'b0, "d1_clr");
      idle(1, "d1_hold");

      // Four digits, full ripple.
      add(4, 32'h9999, 32'h0001, 1'b0, 32'h0000, 1'b1, 1'b0, "d4_ripple");
      add(4, 32'h1234, 32'h5678, 1'b1, 32'h6913, 1'b0, 1'b0, "d4_mix");
      // Three back-to-back operations, then idle: result must hold.
      add(4, 32'h0500, 32'h0500, 1'b0, 32'h1000, 1'b0, 1'b0, "hs_0");
      add(4, 32'h4999, 32'h5000, 1'b1, 32'h0000, 1'b1, 1'b0, "hs_1");
      add(4, 32'h0042, 32'h0058, 1'b0, 32'h0100, 1'b0, 1'b0, "hs_2");
      idle(4, "hs_idle0");
      idle(4, "hs_idle1");

      // Asynchronous reset between edges while out_valid is high.
      add(1, 32'h4, 32'h4, 1'b0, 32'h8, 1'b0, 1'b0, "pre_rst");
      #2;
      rst = 1'b1;
      #1;
      check("arst_valid", 32'(bus1.out_valid), 32'd0);
      check("arst_sum",   32'(bus1.sum),       32'd0);
      check("arst_cout",  32'(bus1.cout),      32'd0);
      check("arst_err",   32'(bus1.err),       32'd0);
      check("arst4_sum",  32'(bus4.sum),       32'd0);
      held[0] = '0;
      held[1] = '0;
      @(negedge clk);
      bus1.in_valid = 1'b0;
      bus4.in_valid = 1'b0;
      rst = 1'b0;
      idle(1, "post_rst0");
      idle(1, "post_rst1");
      add(1, 32'h6, 32'h7, 1'b0, 32'h3, 1'b1, 1'b0, "post_rst_add");

      // Randomized traffic against the reference model.
      for (int n = 0; n < 300; n++) begin
         rd = ($urandom_range(0, 1) == 0) ? 1 : 4;
         rv = ($urandom_range(0, 3) != 0);
         ra = rnd_operand(rd);
         rb = rnd_operand(rd);
         rc = 1'($urandom_range(0, 1));
         if (rv) exp_q.push_back(model(rd, ra, rb, rc));
         drive(rd, rv, ra, rb, rc);
         sample(rd, (rd == 1) ? "rnd1" : "rnd4");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_bcd_adder
